// File: rtl/sdram_port_arb.sv
// sdram_port_arb: arbitrates download, CPU and video requesters onto one SDRAM command port.
// Build option VID_SLOT_EN: video gets absolute priority on every 4th clkref strobe.
module sdram_port_arb #(
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned TMO    = 15
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              clkref,
   input  logic              dl_req,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_din,
   output logic              dl_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_q,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [15:0]       vid_q,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_wide,
   input  logic              mem_ack,
   input  logic [15:0]       mem_q,
   output logic              busy,
   output logic              tmo_err,
   input  logic              err_clr
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_DL, SEL_CPU, SEL_VID} sel_t;

   state_t            r_state;
   state_t            w_state_nx;
   sel_t              r_sel;
   sel_t              w_pick;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nx;
   logic              w_grant;
   logic              w_fin_ack;
   logic              w_fin_tmo;
   logic              w_fin;

   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [7:0]        r_din;
   logic              r_wide;
   logic              r_mem_req;
   logic              r_dl_ack;
   logic              r_cpu_ack;
   logic              r_vid_ack;
   logic              r_busy;
   logic              r_tmo_err;
   logic [7:0]        r_cpu_q;
   logic [15:0]       r_vid_q;

`ifdef VID_SLOT_EN
   logic [1:0]        r_slot;

   // Slot counter advances on every strobe, whether or not a grant happens
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_slot <= 2'd0;
      end else if (clkref) begin
         r_slot <= r_slot + 2'd1;
      end
   end

   always_comb begin
      w_pick = SEL_NONE;
      if (vid_req && (r_slot == 2'd3)) begin
         w_pick = SEL_VID;
      end else if (dl_req) begin
         w_pick = SEL_DL;
      end else if (cpu_req) begin
         w_pick = SEL_CPU;
      end else if (vid_req) begin
         w_pick = SEL_VID;
      end
   end
`else
   logic              r_last_cpu;

   // Tracks which of cpu/vid won last so ties alternate
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_last_cpu <= 1'b0;
      end else if (w_grant && (w_pick == SEL_CPU)) begin
         r_last_cpu <= 1'b1;
      end else if (w_grant && (w_pick == SEL_VID)) begin
         r_last_cpu <= 1'b0;
      end
   end

   always_comb begin
      w_pick = SEL_NONE;
      if (dl_req) begin
         w_pick = SEL_DL;
      end else if (cpu_req && vid_req) begin
         w_pick = r_last_cpu ? SEL_VID : SEL_CPU;
      end else if (cpu_req) begin
         w_pick = SEL_CPU;
      end else if (vid_req) begin
         w_pick = SEL_VID;
      end
   end
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_grant    = 1'b0;
      w_fin_ack  = 1'b0;
      w_fin_tmo  = 1'b0;
      case (r_state)
         IDLE: begin
            if (clkref && (w_pick != SEL_NONE)) begin
               w_grant    = 1'b1;
               w_cnt_nx   = '0;
               w_state_nx = ISSUE;
            end
         end
         ISSUE: begin
            w_state_nx = WAIT;
         end
         WAIT: begin
            if (mem_ack) begin
               w_fin_ack  = 1'b1;
               w_state_nx = DONE;
            end else if (r_cnt >= CNT_W'(TMO)) begin
               w_fin_tmo  = 1'b1;
               w_state_nx = DONE;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   assign w_fin = w_fin_ack | w_fin_tmo;

   // Command latch, ack pulses and read-data capture
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_sel     <= SEL_NONE;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_din     <= 8'h00;
         r_wide    <= 1'b0;
         r_mem_req <= 1'b0;
         r_dl_ack  <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_vid_ack <= 1'b0;
         r_busy    <= 1'b0;
         r_tmo_err <= 1'b0;
         r_cpu_q   <= 8'h00;
         r_vid_q   <= 16'h0000;
      end else begin
         r_mem_req <= w_grant;
         r_busy    <= (w_state_nx != IDLE);
         r_dl_ack  <= w_fin && (r_sel == SEL_DL);
         r_cpu_ack <= w_fin && (r_sel == SEL_CPU);
         r_vid_ack <= w_fin && (r_sel == SEL_VID);

         if (w_grant) begin
            r_sel <= w_pick;
            case (w_pick)
               SEL_DL: begin
                  r_addr <= dl_addr;
                  r_we   <= 1'b1;
                  r_din  <= dl_din;
                  r_wide <= 1'b0;
               end
               SEL_CPU: begin
                  r_addr <= cpu_addr;
                  r_we   <= cpu_we;
                  r_din  <= cpu_din;
                  r_wide <= 1'b0;
               end
               SEL_VID: begin
                  r_addr <= vid_addr;
                  r_we   <= 1'b0;
                  r_din  <= 8'h00;
                  r_wide <= 1'b1;
               end
               default: begin
               end
            endcase
         end

         if (w_fin && (r_sel == SEL_CPU) && !r_we) begin
            if (w_fin_tmo) begin
               r_cpu_q <= 8'hFF;
            end else begin
               r_cpu_q <= r_addr[0] ? mem_q[15:8] : mem_q[7:0];
            end
         end

         if (w_fin && (r_sel == SEL_VID)) begin
            r_vid_q <= w_fin_tmo ? 16'hFFFF : mem_q;
         end

         // A fresh timeout beats a simultaneous clear
         if (w_fin_tmo) begin
            r_tmo_err <= 1'b1;
         end else if (err_clr) begin
            r_tmo_err <= 1'b0;
         end
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_we   = r_we;
   assign mem_addr = r_addr;
   assign mem_din  = r_din;
   assign mem_wide = r_wide;
   assign dl_ack   = r_dl_ack;
   assign cpu_ack  = r_cpu_ack;
   assign vid_ack  = r_vid_ack;
   assign cpu_q    = r_cpu_q;
   assign vid_q    = r_vid_q;
   assign busy     = r_busy;
   assign tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: reads, priority/alternation, timeout, mid-transaction
// reset and clkref gating. Arbitration expectations follow VID_SLOT_EN.
`timescale 1ns/1ps
module tb_sdram_port_arb;
   localparam int unsigned AW = 23;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          clkref  = 1'b0;
   logic          dl_req  = 1'b0;
   logic [AW-1:0] dl_addr = '0;
   logic [7:0]    dl_din  = 8'h00;
   logic          dl_ack;
   logic          cpu_req = 1'b0;
   logic          cpu_we  = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = 8'h00;
   logic          cpu_ack;
   logic [7:0]    cpu_q;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic [15:0]   vid_q;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_wide;
   logic          mem_ack = 1'b0;
   logic [15:0]   mem_q   = 16'h0000;
   logic          busy;
   logic          tmo_err;
   logic          err_clr = 1'b0;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            ack_dly = 1;   // cycles after ISSUE that mem_ack is driven; 0 = never
   int            ack_at = 0;
   bit            ack_pend = 1'b0;
   bit            ref_auto = 1'b1;
   bit            cpu_keep = 1'b0;
   bit            vid_keep = 1'b0;
   int            n_memreq, n_dl, n_cpu, n_vid, n_ord;
   int            issue_cyc, ack_cyc, strobe_cyc;
   logic [AW-1:0] issue_addr;
   logic          issue_we, issue_wide;
   logic [7:0]    issue_din;
   int            ord [16];
   int            exp_ord [8];

   sdram_port_arb #(.ADDR_W(AW), .TMO(15)) dut (
      .clk_sys(clk_sys), .reset(reset), .clkref(clkref),
      .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_q(cpu_q),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_q(vid_q),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_wide(mem_wide), .mem_ack(mem_ack), .mem_q(mem_q),
      .busy(busy), .tmo_err(tmo_err), .err_clr(err_clr)
   );

   initial forever #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic log_ack(input int id);
      if (n_ord < 16) ord[n_ord] = id;
      n_ord++;
      ack_cyc = cyc;
   endtask

   // One clock: sample outputs 1ns after the edge, then drive the responder and requesters
   task automatic tick();
      @(posedge clk_sys);
      #1;
      cyc++;
      if (mem_req) begin
         n_memreq++;
         issue_cyc  = cyc;
         issue_addr = mem_addr;
         issue_we   = mem_we;
         issue_din  = mem_din;
         issue_wide = mem_wide;
         ack_at     = cyc + ack_dly;
         ack_pend   = (ack_dly != 0);
      end
      if (dl_ack)  begin n_dl++;  log_ack(1); dl_req = 1'b0; end
      if (cpu_ack) begin n_cpu++; log_ack(2); if (!cpu_keep) cpu_req = 1'b0; end
      if (vid_ack) begin n_vid++; log_ack(3); if (!vid_keep) vid_req = 1'b0; end
      mem_ack = ack_pend && (cyc == ack_at);
      if (mem_ack) ack_pend = 1'b0;
      if (ref_auto) clkref = ((cyc % 8) == 0);
   endtask

   task automatic clear_stats();
      n_memreq = 0; n_dl = 0; n_cpu = 0; n_vid = 0; n_ord = 0;
      issue_cyc = 0; ack_cyc = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dl_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
      cpu_keep = 1'b0; vid_keep = 1'b0; err_clr = 1'b0;
      ack_pend = 1'b0; mem_ack = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      clear_stats();
   endtask

   task automatic wait_acks(input int target, input int budget, input string tag);
      int n = 0;
      while (n_ord < target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(n_ord >= target), 32'd1);
   endtask

   task automatic wait_issue(input int budget, input string tag);
      int n = 0;
      while (n_memreq == 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(n_memreq > 0), 32'd1);
   endtask

   initial begin
      clear_stats();
      // reset values
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_memreq", 32'(mem_req), 0);
      chk("rst_acks", 32'({dl_ack, cpu_ack, vid_ack}), 0);
      chk("rst_q", 32'({cpu_q, vid_q}), 0);
      chk("rst_tmo", 32'(tmo_err), 0);
      chk("rst_memaddr", 32'(mem_addr), 0);
      chk("rst_memctl", 32'({mem_we, mem_wide, mem_din}), 0);
      reset = 1'b0;

      // cpu read of odd address, ack two cycles after the command
      do_reset();
      cpu_addr = 23'h000001; cpu_we = 1'b0; mem_q = 16'hBEEF; ack_dly = 2;
      cpu_req = 1'b1;
      wait_acks(1, 40, "cpu_rd_wait");
      repeat (6) tick();
      chk("cpu_rd_q", 32'(cpu_q), 32'h0000_00BE);
      chk("cpu_rd_acks", n_cpu, 1);
      chk("cpu_rd_memreq", n_memreq, 1);
      chk("cpu_rd_wide", 32'(issue_wide), 0);
      chk("cpu_rd_addr", 32'(issue_addr), 32'h1);
      chk("cpu_rd_lat", ack_cyc - issue_cyc, 3);
      chk("cpu_rd_idle", 32'(busy), 0);

      // vid read, immediate ack; cpu_q must hold
      clear_stats();
      vid_addr = 23'h000010; mem_q = 16'h1234; ack_dly = 1;
      vid_req = 1'b1;
      wait_acks(1, 40, "vid_rd_wait");
      chk("vid_rd_q", 32'(vid_q), 32'h1234);
      chk("vid_rd_wide", 32'(issue_wide), 1);
      chk("vid_rd_lat", ack_cyc - issue_cyc, 2);
      chk("vid_rd_cpuq_hold", 32'(cpu_q), 32'hBE);

      // cpu read of even address selects the low byte
      clear_stats();
      cpu_addr = 23'h0001F0; mem_q = 16'hA55A;
      cpu_req = 1'b1;
      wait_acks(1, 40, "cpu_even_wait");
      chk("cpu_even_q", 32'(cpu_q), 32'h5A);
      chk("cpu_even_vidq_hold", 32'(vid_q), 32'h1234);

      // all three from reset: dl first, then cpu/vid arbitration with cpu held
      do_reset();
      dl_addr = 23'h012345; dl_din = 8'h77; cpu_addr = 23'h000002; vid_addr = 23'h000100;
      ack_dly = 1; cpu_keep = 1'b1;
      dl_req = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
      wait_acks(1, 40, "prio_first_wait");
      chk("dl_we", 32'(issue_we), 1);
      chk("dl_addr", 32'(issue_addr), 32'h012345);
      chk("dl_din", 32'(issue_din), 32'h77);
      wait_acks(4, 80, "prio_wait");
      cpu_keep = 1'b0; cpu_req = 1'b0;
      repeat (20) tick();
`ifdef VID_SLOT_EN
      exp_ord[0] = 1; exp_ord[1] = 2; exp_ord[2] = 2; exp_ord[3] = 3;
`else
      exp_ord[0] = 1; exp_ord[1] = 2; exp_ord[2] = 3; exp_ord[3] = 2;
`endif
      for (int i = 0; i < 4; i++) chk($sformatf("prio_ord%0d", i), ord[i], exp_ord[i]);
      chk("prio_n_dl", n_dl, 1);
      chk("prio_n_cpu", n_cpu, 2);
      chk("prio_n_vid", n_vid, 1);
      chk("prio_n_memreq", n_memreq, 4);

      // timeout: no mem_ack at all
      do_reset();
      cpu_addr = 23'h000002; ack_dly = 0;
      cpu_req = 1'b1;
      wait_acks(1, 60, "tmo_wait");
      chk("tmo_lat", ack_cyc - issue_cyc, 17);
      chk("tmo_cpuq", 32'(cpu_q), 32'hFF);
      repeat (3) tick();
      chk("tmo_flag", 32'(tmo_err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("tmo_clr", 32'(tmo_err), 0);

      // vid timeout with err_clr on the very cycle the timeout fires
      clear_stats();
      vid_addr = 23'h000004;
      vid_req = 1'b1;
      for (int n = 0; n < 60 && n_ord == 0; n++) begin
         tick();
         err_clr = (n_memreq > 0) && (cyc == issue_cyc + 16);
      end
      err_clr = 1'b0;
      chk("tmo2_ack", n_vid, 1);
      chk("tmo2_lat", ack_cyc - issue_cyc, 17);
      chk("tmo2_vidq", 32'(vid_q), 32'hFFFF);
      chk("tmo2_flag_wins", 32'(tmo_err), 1);

      // reset during WAIT: outputs clear at once, no ack follows
      clear_stats();
      cpu_addr = 23'h000000; ack_dly = 0;
      cpu_req = 1'b1;
      wait_issue(40, "abort_issue");
      repeat (2) tick();
      chk("abort_busy_pre", 32'(busy), 1);
      reset = 1'b1;
      #2;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_tmo", 32'(tmo_err), 0);
      chk("abort_q", 32'({cpu_q, vid_q}), 0);
      cpu_req = 1'b0; ack_pend = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (30) tick();
      chk("abort_no_ack", n_cpu, 0);
      clear_stats();
      cpu_addr = 23'h000001; mem_q = 16'h3C00; ack_dly = 1;
      cpu_req = 1'b1;
      wait_acks(1, 40, "post_rst_wait");
      repeat (4) tick();
      chk("post_rst_q", 32'(cpu_q), 32'h3C);
      chk("post_rst_acks", n_cpu, 1);

      // cpu and vid both held: alternation or slotting per strobe
      do_reset();
      cpu_addr = 23'h000008; vid_addr = 23'h000200; ack_dly = 1;
      cpu_keep = 1'b1; vid_keep = 1'b1;
      cpu_req = 1'b1; vid_req = 1'b1;
      wait_acks(8, 120, "slot_wait");
      cpu_keep = 1'b0; vid_keep = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 8; i++) begin
`ifdef VID_SLOT_EN
         exp_ord[i] = ((i % 4) == 3) ? 3 : 2;
`else
         exp_ord[i] = ((i % 2) == 1) ? 3 : 2;
`endif
         chk($sformatf("slot_ord%0d", i), ord[i], exp_ord[i]);
      end

      // clkref gating and dropped request
      do_reset();
      ref_auto = 1'b0; clkref = 1'b0;
      vid_req = 1'b1;
      repeat (5) tick();
      vid_req = 1'b0;
      tick();
      clkref = 1'b1;
      tick();
      clkref = 1'b0;
      repeat (5) tick();
      chk("drop_memreq", n_memreq, 0);
      chk("drop_ack", n_vid, 0);
      cpu_addr = 23'h000000; mem_q = 16'h00C3; ack_dly = 1;
      cpu_req = 1'b1;
      repeat (10) tick();
      chk("gate_no_memreq", n_memreq, 0);
      chk("gate_idle", 32'(busy), 0);
      strobe_cyc = cyc;
      clkref = 1'b1;
      tick();
      clkref = 1'b0;
      chk("gate_issue_cyc", issue_cyc, strobe_cyc + 1);
      chk("gate_memreq", n_memreq, 1);
      wait_acks(1, 20, "gate_wait");
      chk("gate_q", 32'(cpu_q), 32'hC3);
      ref_auto = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 23, the SDRAM byte-address width.
REQ-002 The block SHALL have parameter TMO, default 15, the maximum clk_sys cycles to wait for mem_ack before abort (range 2..255).
REQ-003 The block SHALL have port clk_sys  in  1  single system clock; all logic on posedge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port clkref  in  1  slot strobe (7 MHz enable); a grant may start only on a cycle with clkref=1.
REQ-006 The block SHALL have ports dl_req/dl_addr[ADDR_W]/dl_din[8]  in, and dl_ack  out 1: download writer, write-only.
REQ-007 The block SHALL have ports cpu_req/cpu_we/cpu_addr[ADDR_W]/cpu_din[8]  in, and cpu_ack  out 1, cpu_q  out 8: CPU port.
REQ-008 The block SHALL have ports vid_req/vid_addr[ADDR_W]  in, and vid_ack  out 1, vid_q  out 16: video fetch, read-only.
REQ-009 The block SHALL have ports mem_req/mem_we  out 1, mem_addr  out ADDR_W, mem_din  out 8, mem_wide  out 1 (16-bit read), and mem_ack  in 1, mem_q  in 16: downstream SDRAM command port.
REQ-010 The block SHALL have ports busy  out 1 (not IDLE), tmo_err  out 1 (sticky timeout flag), and err_clr  in 1.

Function
REQ-011 Requesters SHALL hold req and operands stable until their ack pulse; ack is exactly one cycle wide.
REQ-012 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-013 IDLE->ISSUE SHALL occur on the first cycle with clkref=1 and any req pending; the winner is latched in that same cycle.
REQ-014 Priority SHALL be dl > (cpu, vid); cpu and vid SHALL alternate when both are pending (last_cpu bit, reset 0, so cpu wins the first tie).
REQ-015 ISSUE SHALL assert mem_req for one cycle with the latched addr/we/din; mem_wide=1 only for vid; then go to WAIT.
REQ-016 WAIT SHALL count cycles; on mem_ack, capture mem_q and go to DONE; on count reaching TMO without ack, set tmo_err and go to DONE.
REQ-017 DONE SHALL pulse the winner's ack for one cycle; cpu_q = mem_q[7:0] when addr[0]=0, else mem_q[15:8]; vid_q = mem_q; then go to IDLE.
REQ-018 On timeout the ack SHALL still be pulsed, with read data 8'hFF / 16'hFFFF.
REQ-019 cpu_q and vid_q SHALL hold their last value between acks.
REQ-020 mem_ack arriving outside WAIT SHALL be ignored.
REQ-021 A req deasserted before grant SHALL be dropped without an ack; a req deasserted after grant SHALL still receive its ack.
REQ-022 err_clr SHALL clear tmo_err; a simultaneous new timeout SHALL win (flag stays 1).
REQ-023 Minimum turnaround SHALL be 4 cycles (ISSUE, WAIT with immediate ack, DONE, IDLE); back-to-back grants additionally wait for the next clkref.

Reset
REQ-024 Reset SHALL force state IDLE, all outputs 0 (cpu_q=0, vid_q=0, tmo_err=0), last_cpu=0, and the timeout counter 0, immediately and independent of clk_sys.
REQ-025 Reset mid-transaction SHALL abandon the transaction without an ack.

Configuration
REQ-026 With VID_SLOT_EN defined, vid SHALL instead have absolute priority on every 4th clkref strobe (2-bit slot counter, reset 0, slot 3 = video), and in other slots vid SHALL only be granted if dl and cpu are idle.
REQ-027 Without VID_SLOT_EN, arbitration SHALL be exactly as in REQ-014 and no slot counter SHALL exist.

Verification
REQ-028 The bench SHALL cover: cpu read of addr 0x00001 with mem_q=0xBEEF and ack after 2 cycles -> one cpu_ack pulse, cpu_q=0xBE, single mem_req with mem_wide=0.
REQ-029 The bench SHALL cover: dl, cpu and vid requesting together from reset -> grant order dl, cpu, vid, cpu (cpu req held) and each ack pulsed once.
REQ-030 The bench SHALL cover: mem_ack never asserted with TMO=15 -> ack 17 cycles after ISSUE, data 0xFF, tmo_err=1; err_clr -> tmo_err=0.
REQ-031 The bench SHALL cover: reset asserted during WAIT -> outputs 0 asynchronously, no ack; after release a new cpu_req is served normally.
REQ-032 The bench SHALL cover: VID_SLOT_EN defined with cpu continuously requesting -> vid granted exactly on every 4th clkref.
REQ-033 The bench SHALL cover: req asserted while clkref=0 -> mem_req does not rise before the next clkref cycle.
